// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stage buffers: default widths,
// the bubble control value and the control-word field layout so every
// stage packs and unpacks its control word the same way.
package pipe_pkg;

    localparam int PIPE_CTRL_W = 10;
    localparam int PIPE_PC_W   = 48;

    // Control value of a bubble: all enables low, so a NOP has no side effects.
    localparam logic [PIPE_CTRL_W-1:0] PIPE_NOP_CTRL = 10'd0;

    // Control-word field positions.
    localparam int CTRL_REG_WE     = 0;
    localparam int CTRL_MEM_RD     = 1;
    localparam int CTRL_MEM_WR     = 2;
    localparam int CTRL_BRANCH     = 3;
    localparam int CTRL_ALU_OP_LSB = 4;
    localparam int CTRL_ALU_OP_MSB = 7;
    localparam int CTRL_WB_SEL_LSB = 8;
    localparam int CTRL_WB_SEL_MSB = 9;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    // Number of beats held by a main/skid register pair.
    function automatic logic [1:0] occupancy_of(input logic m_valid, input logic s_valid);
        return {1'b0, m_valid} + {1'b0, s_valid};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: a valid bit plus a payload register.
// clr empties the slot and wins over load; the payload is kept when the
// slot empties so downstream data/PC lines stay quiet during bubbles.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         valid_r;
    logic [W-1:0] q_r;

    // Slot state: reset, clear, load or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            q_r     <= {W{1'b0}};
        end else if (clr) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            q_r     <= d;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign q     = q_r;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline stage register with a one-entry skid slot, synchronous
// flush with bubble insertion and a saturating stall-cycle counter.
// M drives the outputs; S catches the beat accepted while M is stalled,
// which keeps in_ready a function of registered state only.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int                CTRL_W      = PIPE_CTRL_W,
    parameter int                DATA_W      = 32,
    parameter int                PC_W        = PIPE_PC_W,
    parameter logic [CTRL_W-1:0] NOP_CTRL    = CTRL_W'(PIPE_NOP_CTRL),
    parameter int                STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [PC_W-1:0]        in_pc,
    input  logic                   in_irq,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [PC_W-1:0]        out_pc,
    output logic                   out_irq,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int PW = CTRL_W + DATA_W + PC_W + 1;

    logic          m_valid_s, s_valid_s;
    logic [PW-1:0] m_q_s, s_q_s, m_d_s, in_beat_s;
    logic          m_load_s, m_clr_s, s_load_s, s_clr_s;
    logic          accept_s, deliver_s;
    logic [CTRL_W-1:0]      m_ctrl_s;
    logic                   m_irq_s;
    logic [STALL_CNT_W-1:0] stall_r;

    assign in_beat_s = {in_ctrl, in_data, in_pc, in_irq};
    assign in_ready  = ~s_valid_s & ~rst;
    assign accept_s  = in_valid & in_ready;
    assign deliver_s = m_valid_s & out_ready;

    // Slot control: flush empties both slots; otherwise M refills from S
    // first (ordering), then from the input, and S only catches a beat
    // accepted while M is stalled.
    always_comb begin
        m_load_s = 1'b0;
        m_clr_s  = 1'b0;
        s_load_s = 1'b0;
        s_clr_s  = 1'b0;
        m_d_s    = in_beat_s;
        if (flush) begin
            m_clr_s = 1'b1;
            s_clr_s = 1'b1;
        end else if (!m_valid_s || deliver_s) begin
            if (s_valid_s) begin
                m_load_s = 1'b1;
                m_d_s    = s_q_s;
                s_clr_s  = 1'b1;
            end else if (accept_s) begin
                m_load_s = 1'b1;
            end else begin
                m_clr_s = 1'b1;
            end
        end else begin
            if (accept_s) begin
                s_load_s = 1'b1;
            end else begin
                s_load_s = 1'b0;
            end
        end
    end

    pipe_slot #(.W(PW)) u_m_slot (
        .clk   (clk),
        .rst   (rst),
        .clr   (m_clr_s),
        .load  (m_load_s),
        .d     (m_d_s),
        .valid (m_valid_s),
        .q     (m_q_s)
    );

    pipe_slot #(.W(PW)) u_s_slot (
        .clk   (clk),
        .rst   (rst),
        .clr   (s_clr_s),
        .load  (s_load_s),
        .d     (in_beat_s),
        .valid (s_valid_s),
        .q     (s_q_s)
    );

    // Stall counter: counts presented-but-refused cycles, sticks at all-ones,
    // survives flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_r <= {STALL_CNT_W{1'b0}};
        end else if (m_valid_s && !out_ready && (stall_r != {STALL_CNT_W{1'b1}})) begin
            stall_r <= stall_r + STALL_CNT_W'(1);
        end else begin
            stall_r <= stall_r;
        end
    end

    assign {m_ctrl_s, out_data, out_pc, m_irq_s} = m_q_s;
    assign out_valid    = m_valid_s;
    assign out_ctrl     = m_valid_s ? m_ctrl_s : NOP_CTRL;
    assign out_irq      = m_valid_s & m_irq_s;
    assign occupancy    = occupancy_of(m_valid_s, s_valid_s);
    assign stall_cycles = stall_r;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Self-checking bench for pipe_stage_buffer: a queue models the buffer
// contents in acceptance order; a vector table covers the skid and flush
// corners, and short sequences cover streaming, irq, reset and saturation.
module tb_pipe_stage_buffer;

    localparam int CTRL_W  = 10;
    localparam int DATA_W  = 32;
    localparam int PC_W    = 48;
    localparam int SCW     = 4;
    localparam logic [CTRL_W-1:0] NOP = 10'd0;
    localparam int STALL_MAX = 15;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
        logic              irq;
    } beat_t;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        e_valid;
        logic [31:0] e_data;
        logic [1:0]  e_occ;
        logic        e_rdy;
        int          e_stall;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready, in_irq;
    logic              out_valid, out_ready, out_irq;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [DATA_W-1:0] in_data, out_data;
    logic [PC_W-1:0]   in_pc, out_pc;
    logic [1:0]        occupancy;
    logic [SCW-1:0]    stall_cycles;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    beat_t       sb_q[$];
    int          stall_m = 0;
    logic [31:0] last_data = 32'd0;
    logic [47:0] last_pc = 48'd0;

    vec_t  tbl[11];
    beat_t irq_beats[3];

    always #5 clk = ~clk;

    pipe_stage_buffer #(
        .CTRL_W      (CTRL_W),
        .DATA_W      (DATA_W),
        .PC_W        (PC_W),
        .NOP_CTRL    (NOP),
        .STALL_CNT_W (SCW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ctrl      (in_ctrl),
        .in_data      (in_data),
        .in_pc        (in_pc),
        .in_irq       (in_irq),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ctrl     (out_ctrl),
        .out_data     (out_data),
        .out_pc       (out_pc),
        .out_irq      (out_irq),
        .occupancy    (occupancy),
        .stall_cycles (stall_cycles)
    );

    function automatic beat_t mk(input logic [31:0] d, input logic irq);
        beat_t b;
        b.ctrl = 10'h200 | {6'd0, d[3:0]};
        b.data = d;
        b.pc   = 48'h0000_8000_0000 + {16'd0, d} * 48'd4;
        b.irq  = irq;
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    // Drive one cycle, advance the model across the edge and compare all outputs.
    task automatic tick(input logic v, input beat_t b, input logic ordy,
                        input logic fl, input logic r);
        logic acc, del, stl;
        in_valid  = v;
        in_ctrl   = b.ctrl;
        in_data   = b.data;
        in_pc     = b.pc;
        in_irq    = b.irq;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        #1;
        chk("in_ready", in_ready, (!r && sb_q.size() < 2) ? 64'd1 : 64'd0);
        acc = v && !r && (sb_q.size() < 2);
        del = (sb_q.size() > 0) && ordy;
        stl = (sb_q.size() > 0) && !ordy;
        @(posedge clk);
        #1;
        if (r) begin
            sb_q.delete();
            stall_m   = 0;
            last_data = 32'd0;
            last_pc   = 48'd0;
        end else begin
            if (stl && stall_m != STALL_MAX) stall_m++;
            if (del) void'(sb_q.pop_front());
            if (fl) sb_q.delete();
            else if (acc) sb_q.push_back(b);
            if (sb_q.size() > 0) begin
                last_data = sb_q[0].data;
                last_pc   = sb_q[0].pc;
            end
        end
        chk("out_valid", out_valid, (sb_q.size() > 0) ? 64'd1 : 64'd0);
        chk("occupancy", occupancy, 64'(sb_q.size()));
        chk("stall_cycles", stall_cycles, 64'(stall_m));
        if (sb_q.size() > 0) begin
            chk("out_ctrl", out_ctrl, 64'(sb_q[0].ctrl));
            chk("out_data", out_data, 64'(sb_q[0].data));
            chk("out_pc", out_pc, 64'(sb_q[0].pc));
            chk("out_irq", out_irq, 64'(sb_q[0].irq));
        end else begin
            chk("out_ctrl_nop", out_ctrl, 64'(NOP));
            chk("out_irq_idle", out_irq, 64'd0);
            chk("out_data_hold", out_data, 64'(last_data));
            chk("out_pc_hold", out_pc, 64'(last_pc));
        end
    endtask

    initial begin
        int idx;
        int irq_deliv;
        logic ordy;
        logic will_acc;

        //        v     d       ordy  fl    valid e_data  occ   rdy   stall
        tbl[0]  = '{1'b1, 32'hA, 1'b1, 1'b0, 1'b1, 32'hA, 2'd1, 1'b1, 0};
        tbl[1]  = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0, 1};
        tbl[2]  = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0, 2};
        tbl[3]  = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0, 3};
        tbl[4]  = '{1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 32'hB, 2'd1, 1'b1, 3};
        tbl[5]  = '{1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 32'hC, 2'd1, 1'b1, 3};
        tbl[6]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'hC, 2'd0, 1'b1, 3};
        tbl[7]  = '{1'b1, 32'hD, 1'b0, 1'b0, 1'b1, 32'hD, 2'd1, 1'b1, 3};
        tbl[8]  = '{1'b1, 32'hE, 1'b0, 1'b0, 1'b1, 32'hD, 2'd2, 1'b0, 4};
        tbl[9]  = '{1'b1, 32'hF, 1'b0, 1'b1, 1'b0, 32'hD, 2'd0, 1'b1, 5};
        tbl[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'hD, 2'd0, 1'b1, 5};

        // Reset state
        tick(1'b0, mk(32'h0, 1'b0), 1'b0, 1'b0, 1'b1);
        tick(1'b0, mk(32'h0, 1'b0), 1'b0, 1'b0, 1'b1);
        chk("reset_stall", stall_cycles, 64'd0);
        chk("reset_out_data", out_data, 64'd0);

        // Skid and flush vectors
        for (int i = 0; i < 11; i++) begin
            tick(tbl[i].v, mk(tbl[i].d, 1'b0), tbl[i].ordy, tbl[i].fl, 1'b0);
            chk($sformatf("vec%0d_valid", i), out_valid, 64'(tbl[i].e_valid));
            chk($sformatf("vec%0d_data", i), out_data, 64'(tbl[i].e_data));
            chk($sformatf("vec%0d_occ", i), occupancy, 64'(tbl[i].e_occ));
            chk($sformatf("vec%0d_rdy", i), in_ready, 64'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_stall", i), stall_cycles, 64'(tbl[i].e_stall));
            if (i >= 9) chk($sformatf("vec%0d_nop", i), out_ctrl, 64'(NOP));
        end

        // Streaming: 8 back-to-back beats, one cycle latency
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, mk(32'(i), 1'b0), 1'b1, 1'b0, 1'b0);
            chk("stream_data", out_data, 64'(i));
        end
        tick(1'b0, mk(32'h0, 1'b0), 1'b1, 1'b0, 1'b0);
        chk("stream_stall", stall_cycles, 64'd5);

        // Irq sideband under a random out_ready pattern
        irq_beats[0] = mk(32'h4, 1'b0);
        irq_beats[1] = mk(32'h5, 1'b1);
        irq_beats[2] = mk(32'h6, 1'b0);
        idx = 0;
        irq_deliv = 0;
        for (int c = 0; c < 60 && (idx < 3 || sb_q.size() > 0); c++) begin
            ordy = (c >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
            will_acc = (idx < 3) && (sb_q.size() < 2);
            if (out_valid && ordy && out_irq) begin
                irq_deliv++;
                chk("irq_beat_data", out_data, 64'h5);
            end
            tick(idx < 3, irq_beats[(idx < 3) ? idx : 0], ordy, 1'b0, 1'b0);
            if (will_acc) idx++;
        end
        chk("irq_drained", (idx == 3 && sb_q.size() == 0) ? 64'd1 : 64'd0, 64'd1);
        chk("irq_once", 64'(irq_deliv), 64'd1);

        // Reset mid-stall
        tick(1'b1, mk(32'h11, 1'b1), 1'b0, 1'b0, 1'b0);
        tick(1'b1, mk(32'h12, 1'b0), 1'b0, 1'b0, 1'b0);
        chk("pre_reset_occ", occupancy, 64'd2);
        tick(1'b1, mk(32'h13, 1'b0), 1'b0, 1'b0, 1'b1);
        chk("midrst_stall", stall_cycles, 64'd0);
        chk("midrst_data", out_data, 64'd0);
        chk("midrst_pc", out_pc, 64'd0);
        tick(1'b1, mk(32'h13, 1'b0), 1'b0, 1'b0, 1'b1);
        tick(1'b1, mk(32'h14, 1'b0), 1'b0, 1'b0, 1'b0);

        // Saturation: 20 refused cycles on a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, mk(32'h0, 1'b0), 1'b0, 1'b0, 1'b0);
        end
        chk("stall_saturated", stall_cycles, 64'd15);
        tick(1'b0, mk(32'h0, 1'b0), 1'b1, 1'b0, 1'b0);
        chk("sat_drain_data", out_data, 64'h14);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
